// File: rtl/fc_pass_scheduler.sv
// Pass sequencer for one fully-connected layer: launches the control unit once per neuron group,
// writes the lane results out serially, then hands off. Optional watchdog: define PASS_TIMEOUT_EN.
module fc_pass_scheduler #(
  parameter int NUM_OUT = 10,
  parameter int PAR_OUT = 4,
  parameter int TIMEOUT = 256,
  localparam int NUM_PASSES = (NUM_OUT + PAR_OUT - 1) / PAR_OUT,
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1,
  localparam int LANE_W = (PAR_OUT > 1) ? $clog2(PAR_OUT) : 1,
  localparam int ADDR_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_from_previous,
  output logic              end_to_previous,
  output logic              cu_start,
  input  logic              cu_output_ready,
  output logic [PASS_W-1:0] wm_bank_sel,
  output logic [LANE_W-1:0] lane_sel,
  output logic              ofm_wr_en,
  output logic [ADDR_W-1:0] ofm_wr_addr,
  input  logic              next_ready,
  output logic              start_to_next,
  output logic              layer_done,
  output logic              busy,
  output logic              error
);

  localparam int LAST_LANES = NUM_OUT - (NUM_PASSES - 1) * PAR_OUT;
  localparam logic [PASS_W-1:0] LAST_PASS      = PASS_W'(NUM_PASSES - 1);
  localparam logic [LANE_W-1:0] FULL_LAST_LANE = LANE_W'(PAR_OUT - 1);
  localparam logic [LANE_W-1:0] TAIL_LAST_LANE = LANE_W'(LAST_LANES - 1);

  if (PAR_OUT < 1 || PAR_OUT > NUM_OUT || TIMEOUT < 1) begin : g_bad_params
    $error("fc_pass_scheduler: illegal NUM_OUT/PAR_OUT/TIMEOUT combination");
  end

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_CU, WRITE, HANDOFF
  } state_t;

  state_t            r_state, w_state_next;
  logic [PASS_W-1:0] r_pass, w_pass_next;
  logic [LANE_W-1:0] r_lane, w_lane_next;
  logic [LANE_W-1:0] w_last_lane;
  logic              w_timeout;

`ifdef PASS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;

  assign w_timeout = (r_state == WAIT_CU) && !cu_output_ready &&
                     (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == LAUNCH)
        r_tmo <= '0;
      else if (r_state == WAIT_CU)
        r_tmo <= r_tmo + 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign error = r_err;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  // The final pass may be partial; its padded lanes are never written.
  assign w_last_lane = (r_pass == LAST_PASS) ? TAIL_LAST_LANE : FULL_LAST_LANE;

  always_comb begin
    w_state_next = r_state;
    w_pass_next  = r_pass;
    w_lane_next  = r_lane;
    case (r_state)
      IDLE: begin
        if (start_from_previous) begin
          w_state_next = LAUNCH;
          w_pass_next  = '0;
          w_lane_next  = '0;
        end
      end
      LAUNCH: w_state_next = WAIT_CU;
      WAIT_CU: begin
        if (cu_output_ready) begin
          w_state_next = WRITE;
          w_lane_next  = '0;
        end else if (w_timeout) begin
          w_state_next = IDLE;
          w_pass_next  = '0;
          w_lane_next  = '0;
        end
      end
      WRITE: begin
        if (r_lane == w_last_lane) begin
          if (r_pass != LAST_PASS) begin
            w_state_next = LAUNCH;
            w_pass_next  = r_pass + 1'b1;
            w_lane_next  = '0;
          end else begin
            w_state_next = HANDOFF;
          end
        end else begin
          w_lane_next = r_lane + 1'b1;
        end
      end
      HANDOFF: begin
        if (next_ready) begin
          w_state_next = IDLE;
          w_pass_next  = '0;
          w_lane_next  = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_pass_next  = '0;
        w_lane_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pass  <= '0;
      r_lane  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pass  <= w_pass_next;
      r_lane  <= w_lane_next;
    end
  end

  assign end_to_previous = (r_state == IDLE);
  assign busy            = (r_state != IDLE);
  assign cu_start        = (r_state == LAUNCH);
  assign ofm_wr_en       = (r_state == WRITE);
  assign wm_bank_sel     = r_pass;
  assign lane_sel        = r_lane;
  assign ofm_wr_addr     = ADDR_W'(int'(r_pass) * PAR_OUT + int'(r_lane));
  assign start_to_next   = (r_state == HANDOFF) && next_ready;
  assign layer_done      = (r_state == HANDOFF) && next_ready;

endmodule

// File: tb/tb_fc_pass_scheduler.sv
// Directed bench for fc_pass_scheduler: a 10/4 instance (partial last pass) and an 8/4 instance
// run side by side, each with a fixed-latency control-unit model.
module tb_fc_pass_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sfp = 1'b0, sfp_b = 1'b0, next_ready = 1'b1, spur = 1'b0;
  logic rdy_a = 1'b0, rdy_b = 1'b0;

  logic       etp_a, cu_start_a, wr_a, stn_a, ld_a, busy_a, err_a;
  logic [1:0] bank_a, lane_a;
  logic [3:0] addr_a;
  logic       etp_b, cu_start_b, wr_b, stn_b, ld_b, busy_b, err_b;
  logic [0:0] bank_b;
  logic [1:0] lane_b;
  logic [2:0] addr_b;

  always #5 clk = ~clk;

  fc_pass_scheduler #(.NUM_OUT(10), .PAR_OUT(4), .TIMEOUT(16)) u_dut_a (
    .clk(clk), .reset(reset), .start_from_previous(sfp), .end_to_previous(etp_a),
    .cu_start(cu_start_a), .cu_output_ready(rdy_a | spur), .wm_bank_sel(bank_a),
    .lane_sel(lane_a), .ofm_wr_en(wr_a), .ofm_wr_addr(addr_a), .next_ready(next_ready),
    .start_to_next(stn_a), .layer_done(ld_a), .busy(busy_a), .error(err_a)
  );

  fc_pass_scheduler #(.NUM_OUT(8), .PAR_OUT(4), .TIMEOUT(16)) u_dut_b (
    .clk(clk), .reset(reset), .start_from_previous(sfp_b), .end_to_previous(etp_b),
    .cu_start(cu_start_b), .cu_output_ready(rdy_b), .wm_bank_sel(bank_b),
    .lane_sel(lane_b), .ofm_wr_en(wr_b), .ofm_wr_addr(addr_b), .next_ready(next_ready),
    .start_to_next(stn_b), .layer_done(ld_b), .busy(busy_b), .error(err_b)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Control-unit model: answers cu_lat cycles after each cu_start while enabled.
  int cu_lat = 40;
  bit cu_en = 1'b1;
  int cnt_a = 0, cnt_b = 0;
  always @(negedge clk) begin
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    if (reset) begin
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (cnt_a > 0) begin cnt_a--; if (cnt_a == 0) rdy_a = 1'b1; end
      if (cnt_b > 0) begin cnt_b--; if (cnt_b == 0) rdy_b = 1'b1; end
      if (cu_start_a && cu_en) cnt_a = cu_lat;
      if (cu_start_b && cu_en) cnt_b = cu_lat;
    end
  end

  int addr_log[2][256];
  int lane_log[2][256];
  int bank_log[2][64];
  int n_wr[2], n_launch[2], n_done[2];
  int base_wr[2], base_launch[2], base_done[2];
  int n_pulse_mis = 0;

  task automatic log_sample(input int k, input logic st, input int bank, input logic we,
                            input int addr, input int lane, input logic stn, input logic ld);
    if (st) begin
      if (n_launch[k] < 64) bank_log[k][n_launch[k]] = bank;
      n_launch[k]++;
    end
    if (we) begin
      if (n_wr[k] < 256) begin
        addr_log[k][n_wr[k]] = addr;
        lane_log[k][n_wr[k]] = lane;
      end
      n_wr[k]++;
    end
    if (stn) n_done[k]++;
    if (stn != ld) n_pulse_mis++;
  endtask

  always begin
    @(negedge clk);
    #1;
    log_sample(0, cu_start_a, int'(bank_a), wr_a, int'(addr_a), int'(lane_a), stn_a, ld_a);
    log_sample(1, cu_start_b, int'(bank_b), wr_b, int'(addr_b), int'(lane_b), stn_b, ld_b);
  end

  task automatic take_snapshot();
    for (int k = 0; k < 2; k++) begin
      base_wr[k]     = n_wr[k];
      base_launch[k] = n_launch[k];
      base_done[k]   = n_done[k];
    end
  endtask

  task automatic start_layer(input bit both);
    @(negedge clk);
    sfp   = 1'b1;
    sfp_b = both;
    @(negedge clk);
    sfp   = 1'b0;
    sfp_b = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      #2;
      cyc++;
    end while ((busy_a || busy_b) && cyc < 3000);
    check_eq({tag, "_idle_in_time"}, int'(!busy_a && !busy_b), 1);
  endtask

  // Expected: one launch per group of 4 with bank = pass, addresses 0..no-1, lane = addr mod 4.
  task automatic check_layer(input string tag, input int k, input int no);
    int np = (no + 3) / 4;
    check_eq({tag, "_launches"}, n_launch[k] - base_launch[k], np);
    for (int p = 0; p < np; p++)
      check_eq($sformatf("%s_bank%0d", tag, p), bank_log[k][base_launch[k] + p], p);
    check_eq({tag, "_writes"}, n_wr[k] - base_wr[k], no);
    for (int i = 0; i < no; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), addr_log[k][base_wr[k] + i], i);
      check_eq($sformatf("%s_lane%0d", tag, i), lane_log[k][base_wr[k] + i], i % 4);
    end
    check_eq({tag, "_done_pulses"}, n_done[k] - base_done[k], 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    @(negedge clk);
    #2;
    check_eq("rst_end_to_prev", int'(etp_a), 1);
    check_eq("rst_busy", int'(busy_a), 0);
    check_eq("rst_cu_start", int'(cu_start_a), 0);
    check_eq("rst_wr_en", int'(wr_a), 0);
    check_eq("rst_start_to_next", int'(stn_a), 0);
    check_eq("rst_error", int'(err_a), 0);
    check_eq("rst_bank", int'(bank_a), 0);
    @(negedge clk);
    reset = 1'b0;
    $display("reset released");

    // Full layers: 10/4 with partial pass and 8/4 with none
    take_snapshot();
    start_layer(1'b1);
    wait_idle("t1");
    check_layer("t1a", 0, 10);
    check_layer("t2b", 1, 8);
    check_eq("t1_end_to_prev", int'(etp_a), 1);
    check_eq("t1_error", int'(err_a), 0);
    $display("layer t1/t2 complete");

    // Handoff held off by next_ready
    take_snapshot();
    next_ready = 1'b0;
    start_layer(1'b1);
    begin
      int c = 0;
      while ((n_wr[0] - base_wr[0]) < 10 && c < 3000) begin
        @(negedge clk);
        c++;
      end
    end
    check_eq("t3_writes_reached", n_wr[0] - base_wr[0], 10);
    repeat (20) @(negedge clk);
    #2;
    check_eq("t3_busy_held", int'(busy_a), 1);
    check_eq("t3_busy_held_b", int'(busy_b), 1);
    check_eq("t3_no_pulse", n_done[0] - base_done[0], 0);
    check_eq("t3_no_pulse_b", n_done[1] - base_done[1], 0);
    check_eq("t3_stn_low", int'(stn_a), 0);
    @(negedge clk);
    next_ready = 1'b1;
    #2;
    check_eq("t3_stn_on_ready", int'(stn_a), 1);
    check_eq("t3_ld_on_ready", int'(ld_a), 1);
    check_eq("t3_stn_on_ready_b", int'(stn_b), 1);
    wait_idle("t3");
    check_layer("t3a", 0, 10);
    check_layer("t3b", 1, 8);
    check_eq("t3_end_to_prev", int'(etp_a), 1);
    $display("layer t3 complete");

    // Spurious inputs: ready in IDLE/LAUNCH/WRITE, start during WAIT_CU
    take_snapshot();
    cu_lat = 10;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #2;
    check_eq("t4_idle_spur_busy", int'(busy_a), 0);
    check_eq("t4_idle_spur_launch", n_launch[0] - base_launch[0], 0);
    start_layer(1'b0);
    begin
      int c = 0;
      while (busy_a && c < 3000) begin
        @(negedge clk);
        #2;
        c++;
        spur = cu_start_a | wr_a;
        sfp  = busy_a && !cu_start_a && !wr_a && !stn_a && c[0];
      end
    end
    spur = 1'b0;
    sfp  = 1'b0;
    check_eq("t4_idle_in_time", int'(busy_a), 0);
    check_layer("t4a", 0, 10);
    repeat (3) @(negedge clk);
    check_eq("t4_no_restart", n_launch[0] - base_launch[0], 3);
    $display("layer t4 complete");

    // Reset during WAIT_CU of pass 1
    take_snapshot();
    cu_lat = 40;
    start_layer(1'b1);
    begin
      int c = 0;
      while ((n_launch[0] - base_launch[0]) < 2 && c < 3000) begin
        @(negedge clk);
        c++;
      end
    end
    check_eq("t5_reached_pass1", n_launch[0] - base_launch[0], 2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check_eq("t5_busy", int'(busy_a), 0);
    check_eq("t5_end_to_prev", int'(etp_a), 1);
    check_eq("t5_error", int'(err_a), 0);
    check_eq("t5_bank", int'(bank_a), 0);
    check_eq("t5_busy_b", int'(busy_b), 0);
    check_eq("t5_writes_before", n_wr[0] - base_wr[0], 4);
    check_eq("t5_no_pulse", n_done[0] - base_done[0], 0);
    @(negedge clk);
    reset = 1'b0;
    take_snapshot();
    start_layer(1'b1);
    wait_idle("t5");
    check_layer("t5a", 0, 10);
    check_layer("t5b", 1, 8);
    $display("layer t5 complete");

`ifdef PASS_TIMEOUT_EN
    // Watchdog: control unit never answers
    take_snapshot();
    cu_en = 1'b0;
    start_layer(1'b0);
    wait_idle("t6");
    check_eq("t6_error_set", int'(err_a), 1);
    check_eq("t6_launches", n_launch[0] - base_launch[0], 1);
    check_eq("t6_no_writes", n_wr[0] - base_wr[0], 0);
    check_eq("t6_no_pulse", n_done[0] - base_done[0], 0);
    cu_en = 1'b1;
    take_snapshot();
    start_layer(1'b0);
    wait_idle("t6g");
    check_layer("t6g", 0, 10);
    check_eq("t6_error_sticky", int'(err_a), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check_eq("t6_error_cleared", int'(err_a), 0);
    @(negedge clk);
    reset = 1'b0;
    $display("layer t6 complete");
`endif

    check_eq("pulse_alignment", n_pulse_mis, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_pass_scheduler.md
Name: fc_pass_scheduler

Overview:
Top-level sequencer for one fully-connected layer whose output neurons are computed PAR_OUT at a time by the FC control unit and its MAC datapath. It launches one pass per neuron group and selects the weight-memory bank for that pass. After each pass it serially writes the PAR_OUT lane results into the output feature buffer, then hands off to the next layer. It sits between the previous-layer handshake and the FC control unit's start/output_ready pair.

Parameters:
NUM_OUT, 10, total output neurons of the layer (>=1)
PAR_OUT, 4, neurons computed in parallel per pass (1..NUM_OUT)
NUM_PASSES, ceil(NUM_OUT/PAR_OUT), derived; number of passes
PASS_W, max(1,$clog2(NUM_PASSES)), derived; pass index width
LANE_W, max(1,$clog2(PAR_OUT)), derived; lane index width
ADDR_W, max(1,$clog2(NUM_OUT)), derived; output buffer address width
TIMEOUT, 256, watchdog limit in cycles; used only with PASS_TIMEOUT_EN

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start_from_previous  in  1  previous layer has data ready; sampled only in IDLE
end_to_previous  out  1  high only in IDLE (scheduler can accept a new layer)
cu_start  out  1  one-cycle start pulse to the FC control unit
cu_output_ready  in  1  one-cycle pulse from the control unit when the pass result is valid
wm_bank_sel  out  PASS_W  current pass index; selects the weight/bias bank
lane_sel  out  LANE_W  result lane currently being written
ofm_wr_en  out  1  output buffer write strobe
ofm_wr_addr  out  ADDR_W  output buffer address = pass*PAR_OUT+lane
next_ready  in  1  next layer can accept
start_to_next  out  1  one-cycle pulse to the next layer
layer_done  out  1  one-cycle pulse, coincident with start_to_next
busy  out  1  high in every state except IDLE
error  out  1  sticky watchdog flag (PASS_TIMEOUT_EN only; else tied 0)

Behaviour:
- FSM states: IDLE, LAUNCH, WAIT_CU, WRITE, HANDOFF. All outputs are registered or decoded from the state.
- Reset (synchronous) forces state=IDLE, pass=0, lane=0, all strobes=0, error=0. end_to_previous=1 from the first cycle after reset. A reset mid-layer aborts without writes or pulses.
- IDLE: end_to_previous=1. If start_from_previous=1, go to LAUNCH with pass=0.
- LAUNCH: cu_start=1 for exactly 1 cycle, wm_bank_sel=pass. Next state is WAIT_CU.
- WAIT_CU: wm_bank_sel is held. On cu_output_ready=1, go to WRITE with lane=0.
- cu_output_ready in any state other than WAIT_CU is ignored. start_from_previous outside IDLE is ignored, with no queuing.
- WRITE: ofm_wr_en=1 every cycle, lane_sel=lane, ofm_wr_addr=pass*PAR_OUT+lane. Lane count for the pass is PAR_OUT, except the last pass, which uses NUM_OUT-(NUM_PASSES-1)*PAR_OUT. Write cycles for padded lanes are never issued.
- After the last lane: if pass<NUM_PASSES-1, increment pass and go to LAUNCH. Otherwise go to HANDOFF.
- HANDOFF: wait for next_ready=1. In the cycle next_ready is sampled high, assert start_to_next=1 and layer_done=1 for one cycle, then go to IDLE.
- If next_ready is already high on entry, the pulse occurs in the first HANDOFF cycle.
- Latency per pass is 1 (LAUNCH) + CU latency + lanes_in_pass cycles. Total writes per layer = NUM_OUT, addresses 0..NUM_OUT-1 ascending, each exactly once.
- The pass and lane counters clear on entry to IDLE; they do not wrap.

Optional Feature:
PASS_TIMEOUT_EN:
- Defined: a counter clears on entering WAIT_CU and increments each WAIT_CU cycle. If it reaches TIMEOUT without cu_output_ready, set error=1 (sticky until reset) and go to IDLE. No layer_done or start_to_next pulse is issued.
- Not defined: no counter. WAIT_CU waits indefinitely and error is constant 0.

Test Plan:
1. NUM_OUT=10, PAR_OUT=4; pulse start_from_previous; CU model returns cu_output_ready 40 cycles after each cu_start; next_ready=1.
   -> 3 cu_start pulses with wm_bank_sel 0,1,2.
   -> Writes to addresses 0-3, 4-7, 8-9 (lane_sel 0-3, 0-3, 0-1); exactly 10 ofm_wr_en cycles.
   -> One start_to_next/layer_done pulse, then end_to_previous=1.
2. NUM_OUT=8, PAR_OUT=4 (no partial pass) -> 2 passes with 4 writes each; last address 7.
3. Hold next_ready=0 for 20 cycles after the final write -> state stays HANDOFF, busy=1, no pulse; the pulse fires in the cycle next_ready rises.
4. Spurious cu_output_ready during LAUNCH/WRITE/IDLE, and start_from_previous pulses during WAIT_CU -> no state change, no extra writes or launches.
5. Assert reset in WAIT_CU of pass 1 -> the next cycle shows IDLE, busy=0, error=0, end_to_previous=1. A new start runs from pass 0 with wm_bank_sel=0.
6. PASS_TIMEOUT_EN, TIMEOUT=16; CU never responds -> error=1 after 16 WAIT_CU cycles and return to IDLE. error stays 1 across a subsequent good layer until reset.
